// File: rtl/regfile_writeback_if.sv
// Purpose: bundle of the writeback block's pipeline, long-latency, reservation and
// register-file write signals.
//   slave  : the writeback block (takes results, drives the register-file write port)
//   master : the environment (pipeline, LU, issue logic)
interface regfile_writeback_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          wb_valid;
   logic [4:0]    wb_rd;
   logic [31:0]   wb_data;
   logic          wb_stall;
   logic          lu_valid;
   logic          lu_ready;
   logic [4:0]    lu_rd;
   logic [31:0]   lu_data;
   logic          rsv_valid;
   logic [4:0]    rsv_rd;
   logic [4:0]    rs1;
   logic [4:0]    rs2;
   logic          busy_rs1;
   logic          busy_rs2;
   logic [4:0]    rf_rd;
   logic [31:0]   rf_data;
   logic          rf_we;
   logic [CW-1:0] fifo_cnt;

   modport slave (
      input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
             rsv_valid, rsv_rd, rs1, rs2,
      output wb_stall, lu_ready, busy_rs1, busy_rs2, rf_rd, rf_data, rf_we, fifo_cnt
   );

   modport master (
      output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
             rsv_valid, rsv_rd, rs1, rs2,
      input  wb_stall, lu_ready, busy_rs1, busy_rs2, rf_rd, rf_data, rf_we, fifo_cnt
   );
endinterface

// File: rtl/regfile_writeback.sv
// Purpose: owns the single register-file write port. Pipeline WB results have
// priority; long-latency (LU) results queue in a FIFO and drain into free slots,
// with a forced drain slot after STARVE_MAX consecutive lost cycles. Tracks busy
// destinations of outstanding LU ops for issue-stage RAW/WAW stalls.
// Ports: clk, rst_n (async active-low), bus (regfile_writeback_if.slave):
//   wb_*  pipeline result + registered wb_stall; lu_* LU result + lu_ready;
//   rsv_* reservation; rs1/rs2 -> busy_rs1/busy_rs2 (combinational);
//   rf_rd/rf_data/rf_we registered write port; fifo_cnt occupancy.
module regfile_writeback #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input logic               clk,
   input logic               rst_n,
   regfile_writeback_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = $clog2(STARVE_MAX) + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] FORCE = 2'd2;

   logic [1:0]    state, state_next;
   logic [SW-1:0] starve, starve_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [31:0]   busy, busy_next;
   logic [4:0]    mem_rd   [DEPTH];
   logic [31:0]   mem_data [DEPTH];

   logic wb_win, fifo_ne, pop, lost, push;
   logic [4:0]  head_rd;
   logic [31:0] head_data;

   // Arbitration: a real WB write wins; otherwise the FIFO head takes the slot.
   // During FORCE wb_stall blocks WB, so the head pops unconditionally.
   always_comb begin
      wb_win    = bus.wb_valid && !bus.wb_stall && (bus.wb_rd != 5'd0);
      fifo_ne   = (cnt != '0);
      pop       = fifo_ne && !wb_win;
      lost      = fifo_ne && wb_win;
      push      = bus.lu_valid && bus.lu_ready && (bus.lu_rd != 5'd0);
      head_rd   = mem_rd[rd_ptr];
      head_data = mem_data[rd_ptr];
      cnt_next  = cnt;
      if (push && !pop)      cnt_next = cnt + CW'(1);
      else if (pop && !push) cnt_next = cnt - CW'(1);
   end

   assign bus.lu_ready = (cnt < CW'(DEPTH));
   assign bus.fifo_cnt = cnt;
   assign bus.busy_rs1 = busy[bus.rs1] && (bus.rs1 != 5'd0);
   assign bus.busy_rs2 = busy[bus.rs2] && (bus.rs2 != 5'd0);

   // Next state and starvation counter.
   always_comb begin
      state_next  = state;
      starve_next = starve;
      case (state)
         IDLE: begin
            if (cnt_next != '0) state_next = DRAIN;
         end
         DRAIN: begin
            if (pop)       starve_next = '0;
            else if (lost) starve_next = starve + SW'(1);
            if (cnt_next == '0) begin
               state_next = IDLE;
            end else if (lost && starve == SW'(STARVE_MAX - 1)) begin
               state_next  = FORCE;
               starve_next = '0;
            end
         end
         FORCE: begin
            starve_next = '0;
            state_next  = (cnt_next != '0) ? DRAIN : IDLE;
         end
         default: begin
            state_next  = IDLE;
            starve_next = '0;
         end
      endcase
   end

   // Busy scoreboard: pop clears, reservation sets (set wins), r0 never busy.
   always_comb begin
      busy_next = busy;
      if (pop) busy_next[head_rd] = 1'b0;
      if (bus.rsv_valid && bus.rsv_rd != 5'd0) busy_next[bus.rsv_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         starve       <= '0;
         cnt          <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         busy         <= '0;
         bus.wb_stall <= 1'b0;
         bus.rf_we    <= 1'b0;
         bus.rf_rd    <= 5'd0;
         bus.rf_data  <= 32'd0;
      end else begin
         state        <= state_next;
         starve       <= starve_next;
         cnt          <= cnt_next;
         busy         <= busy_next;
         bus.wb_stall <= (state_next == FORCE);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (wb_win) begin
            bus.rf_we   <= 1'b1;
            bus.rf_rd   <= bus.wb_rd;
            bus.rf_data <= bus.wb_data;
         end else if (pop) begin
            bus.rf_we   <= 1'b1;
            bus.rf_rd   <= head_rd;
            bus.rf_data <= head_data;
         end else begin
            bus.rf_we   <= 1'b0;
         end
      end
   end

   // FIFO storage needs no reset; occupancy and pointers guard it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_rd[wr_ptr]   <= bus.lu_rd;
         mem_data[wr_ptr] <= bus.lu_data;
      end
   end
endmodule
